// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one single-port memory between a fetch (IF) port and a load/store (D) port.
// Latency: grant cycle + 1 + W wait states to rvalid. Completion is forced with err=1 after TIMEOUT BUSY cycles.
// Backpressure: only one transaction is outstanding. Requesters hold req and payload until gnt. Optional counters are enabled by MEM_ARB_STATS_EN.
module mem_bus_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [DATA_W-1:0]     if_rdata,
    output logic                  if_err,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [DATA_W/8-1:0]   d_be,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_W-1:0]     d_rdata,
    output logic                  d_err,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_W/8-1:0]   mem_be,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic                  mem_ready,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  busy
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [31:0]           stat_if_cnt,
    output logic [31:0]           stat_d_cnt,
    output logic [31:0]           stat_conflict_cnt
`endif
);

    localparam int BE_W  = DATA_W / 8;
    // The wait counter only has to count 0 .. TIMEOUT-1.
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [DATA_W-1:0] ERR_DATA = DATA_W'(32'hDEAD_BEEF);
    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_D  = 1'b1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state, state_nxt;
    logic             last_owner;
    logic             owner;
    logic [CNT_W-1:0] cnt;
    logic             d_win;
    logic             done;
    logic             abort;

    assign busy = (state == BUSY);

    // Grants are combinational. They are held low during reset so that requesters never see a grant that cannot be taken.
    // D wins when it is the only requester, or when IF owned the bus last.
    always_comb begin
        state_nxt = state;
        if_gnt    = 1'b0;
        d_gnt     = 1'b0;
        done      = 1'b0;
        abort     = 1'b0;
        d_win     = d_req && (!if_req || (last_owner == OWN_IF));
        case (state)
            IDLE: begin
                d_gnt  = rst_n && d_win;
                if_gnt = rst_n && if_req && !d_win;
                if (d_gnt || if_gnt) begin
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (mem_ready) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end else if (cnt == CNT_LAST) begin
                    abort     = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Latch the winner's request onto the memory bus and count wait cycles while it is outstanding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_be     <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            owner      <= OWN_IF;
            last_owner <= OWN_IF;
            cnt        <= '0;
        end else if (state == IDLE) begin
            cnt <= '0;
            if (d_gnt) begin
                mem_req    <= 1'b1;
                mem_we     <= d_we;
                mem_be     <= d_be;
                mem_addr   <= d_addr;
                mem_wdata  <= d_wdata;
                owner      <= OWN_D;
                last_owner <= OWN_D;
            end else if (if_gnt) begin
                mem_req    <= 1'b1;
                mem_we     <= 1'b0;
                mem_be     <= {BE_W{1'b1}};
                mem_addr   <= if_addr;
                mem_wdata  <= '0;
                owner      <= OWN_IF;
                last_owner <= OWN_IF;
            end
        end else if (done || abort) begin
            mem_req <= 1'b0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Return the completion to the owner as a one-cycle pulse. rdata holds until that port's next completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_rvalid <= 1'b0;
            if_rdata  <= '0;
            if_err    <= 1'b0;
            d_rvalid  <= 1'b0;
            d_rdata   <= '0;
            d_err     <= 1'b0;
        end else begin
            if_rvalid <= 1'b0;
            d_rvalid  <= 1'b0;
            if (done || abort) begin
                if (owner == OWN_D) begin
                    d_rvalid <= 1'b1;
                    d_err    <= abort;
                    d_rdata  <= abort ? ERR_DATA : (mem_we ? '0 : mem_rdata);
                end else begin
                    if_rvalid <= 1'b1;
                    if_err    <= abort;
                    if_rdata  <= abort ? ERR_DATA : mem_rdata;
                end
            end
        end
    end

`ifdef MEM_ARB_STATS_EN
    // Saturating grant counters and a counter of IDLE cycles in which both ports requested.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_if_cnt       <= '0;
            stat_d_cnt        <= '0;
            stat_conflict_cnt <= '0;
        end else begin
            if (if_gnt && (stat_if_cnt != 32'hFFFF_FFFF)) begin
                stat_if_cnt <= stat_if_cnt + 32'd1;
            end
            if (d_gnt && (stat_d_cnt != 32'hFFFF_FFFF)) begin
                stat_d_cnt <= stat_d_cnt + 32'd1;
            end
            if ((state == IDLE) && if_req && d_req && (stat_conflict_cnt != 32'hFFFF_FFFF)) begin
                stat_conflict_cnt <= stat_conflict_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized scoreboard bench for mem_bus_arbiter. It uses TIMEOUT=8 and a random-latency memory responder.
// The driver predicts grants from the round-robin rule and queues the expected responses. The monitor pops those responses on rvalid.
// Stimulus is applied on the falling edge. Outputs are sampled shortly after it.
module tb_mem_bus_arbiter;

    localparam int TMO = 8;

    logic        clk;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        if_err;
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        d_err;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        busy;
`ifdef MEM_ARB_STATS_EN
    logic [31:0] stat_if_cnt;
    logic [31:0] stat_d_cnt;
    logic [31:0] stat_conflict_cnt;
`endif

    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .busy(busy)
`ifdef MEM_ARB_STATS_EN
        , .stat_if_cnt(stat_if_cnt), .stat_d_cnt(stat_d_cnt),
        .stat_conflict_cnt(stat_conflict_cnt)
`endif
    );

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          due;
    } exp_t;

    exp_t        if_q[$];
    exp_t        d_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    bit          mon_en = 0;
    logic [31:0] last_rd [2];

    // Reference model state, expressed in terms of transactions rather than RTL registers.
    bit          m_busy;
    int          m_last;      // 0 = IF owned the bus last, 1 = D
    int          m_bc;        // BUSY cycles elapsed for the current transaction
    int          m_w;         // wait states the memory inserts for it
    logic [31:0] cur_addr, cur_wdata, cur_rdata;
    logic        cur_we;
    logic [3:0]  cur_be;
    int          cur_owner;
    bit          gr_if, gr_d;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Check one port's response against the head of its expectation queue.
    task automatic mon_port(input int p, input logic rv, input logic [31:0] rd, input logic er);
        exp_t e;
        bit   have;
        have = (p == 0) ? (if_q.size() > 0) : (d_q.size() > 0);
        if (have) e = (p == 0) ? if_q[0] : d_q[0];
        if (rv) begin
            if (!have) begin
                chk(p == 0 ? "if_rvalid_unexpected" : "d_rvalid_unexpected", 64'(rv), 64'd0);
            end else begin
                if (p == 0) void'(if_q.pop_front()); else void'(d_q.pop_front());
                chk(p == 0 ? "if_rdata" : "d_rdata", 64'(rd), 64'(e.data));
                chk(p == 0 ? "if_err" : "d_err", 64'(er), 64'(e.err));
                chk(p == 0 ? "if_rvalid_cycle" : "d_rvalid_cycle", 64'(cyc), 64'(e.due));
                last_rd[p] = e.data;
            end
        end else begin
            chk(p == 0 ? "if_rdata_hold" : "d_rdata_hold", 64'(rd), 64'(last_rd[p]));
            if (have && e.due <= cyc) begin
                chk(p == 0 ? "if_rvalid_missing" : "d_rvalid_missing", 64'(rv), 64'd1);
                if (p == 0) void'(if_q.pop_front()); else void'(d_q.pop_front());
            end
        end
    endtask

    // Monitor: compares completions against the scoreboard independently of the driver.
    always @(negedge clk) begin
        #2;
        if (mon_en && rst_n) begin
            mon_port(0, if_rvalid, if_rdata, if_err);
            mon_port(1, d_rvalid, d_rdata, d_err);
        end
    end

    // One cycle of stimulus, model prediction and bus-side checking.
    task automatic step(input int pct);
        int   win;   // -1 none, 0 IF, 1 D
        int   k;
        exp_t e;
        @(negedge clk);
        if (gr_if) begin if_req = 1'b0; gr_if = 0; end
        if (gr_d)  begin d_req  = 1'b0; gr_d  = 0; end
        if (if_req && $urandom_range(99) < 2) if_req = 1'b0;
        else if (!if_req && $urandom_range(99) < pct) begin
            if_req  = 1'b1;
            if_addr = $urandom & 32'hFFFF_FFFC;
        end
        if (d_req && $urandom_range(99) < 2) d_req = 1'b0;
        else if (!d_req && $urandom_range(99) < pct) begin
            d_req   = 1'b1;
            d_we    = 1'($urandom_range(1));
            d_be    = 4'($urandom_range(15));
            d_addr  = $urandom;
            d_wdata = $urandom;
        end
        if (m_busy) begin
            mem_ready = (m_w < TMO) && (m_bc == m_w);
            mem_rdata = mem_ready ? cur_rdata : $urandom;
        end else begin
            mem_ready = ($urandom_range(3) == 0);
            mem_rdata = $urandom;
        end
        #1;
        chk("busy", 64'(busy), 64'(m_busy));
        chk("mem_req", 64'(mem_req), 64'(m_busy));
        win = -1;
        if (m_busy) begin
            chk("gnt_while_busy", {62'd0, if_gnt, d_gnt}, 64'd0);
            chk("mem_addr", 64'(mem_addr), 64'(cur_addr));
            chk("mem_we", 64'(mem_we), 64'(cur_we));
            chk("mem_be", 64'(mem_be), 64'(cur_be));
            if (cur_owner == 1) chk("mem_wdata", 64'(mem_wdata), 64'(cur_wdata));
        end else begin
            if (if_req && d_req) win = (m_last == 0) ? 1 : 0;
            else if (d_req)      win = 1;
            else if (if_req)     win = 0;
            chk("if_gnt", 64'(if_gnt), 64'(win == 0));
            chk("d_gnt", 64'(d_gnt), 64'(win == 1));
        end
        if (m_busy) begin
            m_bc++;
            if (mem_ready || m_bc == TMO) m_busy = 0;
        end else if (win >= 0) begin
            cur_owner = win;
            cur_addr  = (win == 1) ? d_addr : if_addr;
            cur_we    = (win == 1) ? d_we : 1'b0;
            cur_be    = (win == 1) ? d_be : 4'hF;
            cur_wdata = d_wdata;
            cur_rdata = $urandom;
            m_w       = ($urandom_range(3) == 0) ? $urandom_range(10) : $urandom_range(3);
            k         = (m_w < TMO) ? m_w + 1 : TMO;
            e.err     = (m_w >= TMO);
            e.data    = e.err ? 32'hDEAD_BEEF : (cur_we ? 32'd0 : cur_rdata);
            e.due     = cyc + k + 1;
            if (win == 1) begin d_q.push_back(e); gr_d = 1; end
            else begin if_q.push_back(e); gr_if = 1; end
            m_busy = 1;
            m_bc   = 0;
            m_last = win;
        end
    endtask

    task automatic model_clear();
        m_busy = 0; m_last = 0; m_bc = 0; gr_if = 0; gr_d = 0;
        if_q.delete(); d_q.delete();
        last_rd[0] = 32'd0; last_rd[1] = 32'd0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctl"}, {53'd0, if_gnt, if_rvalid, if_err, d_gnt, d_rvalid, d_err,
                            mem_req, mem_we, busy, mem_be}, 64'd0);
        chk({tag, "_if_rdata"}, 64'(if_rdata), 64'd0);
        chk({tag, "_d_rdata"}, 64'(d_rdata), 64'd0);
        chk({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
        chk({tag, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        if_req = 1'b1; if_addr = 32'h100;
        d_req = 1'b1; d_we = 1'b1; d_be = 4'hF; d_addr = 32'h2000; d_wdata = 32'h1234;
        mem_ready = 1'b1; mem_rdata = 32'h13;
        model_clear();
        repeat (3) @(negedge clk);
        #1;
        chk_all_zero("reset");
        if_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0;
        rst_n = 1'b1;
        mon_en = 1;

        // Continuous contention right after reset: D first, then alternate.
        repeat (80) step(100);
        // Mixed random traffic, including timeouts (waits >= TMO) and ready pulses while idle.
        repeat (3000) step(40);
        repeat (1500) step(10);

        // Async reset in the middle of an outstanding transaction.
        n = 0;
        while (!m_busy && n < 200) begin step(60); n++; end
        chk("reach_busy", 64'(m_busy), 64'd1);
        @(posedge clk);
        #3;
        mon_en = 0;
        rst_n  = 1'b0;
        #1;
        chk("async_mem_req", 64'(mem_req), 64'd0);
        chk("async_busy", 64'(busy), 64'd0);
        chk_all_zero("async");
        if_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1;
        // No stale rvalid may follow the release.
        repeat (20) step(0);
        repeat (800) step(50);

        // Drain and confirm every expected response arrived.
        repeat (30) step(0);
        chk("drain", 64'(if_q.size() + d_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute watchdog so the run always ends with a summary.
    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog got timeout expected finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
